modulo_secuenciador: RTL

//  Sequencer for the SECDED Hamming(7,4)+global-parity decoder. Accepts a received
//  8-bit word over valid/ready and drives the syndrome-compare stage (modulo_03 instance).

---
 rtl/modulo_secuenciador_if.sv | 30 +++
 rtl/modulo_secuenciador.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/modulo_secuenciador_if.sv
// Word-in / decoded-result-out bundle for the SECDED sequencer, plus counter clear and statistics.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface modulo_secuenciador_if #(
    parameter int CNT_W = 8
);
    logic             valid_in;
    logic             ready_in;
    logic [7:0]       palabra_in;
    logic             valid_out;
    logic             ready_out;
    logic [3:0]       dato_out;
    logic [6:0]       palabra_corr;
    logic [2:0]       pos_out;
    logic [1:0]       estado_err;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_simple;
    logic [CNT_W-1:0] cnt_doble;

    modport master (
        output valid_in, palabra_in, ready_out, clr_cnt,
        input  ready_in, valid_out, dato_out, palabra_corr, pos_out, estado_err,
               cnt_simple, cnt_doble
    );

    modport slave (
        input  valid_in, palabra_in, ready_out, clr_cnt,
        output ready_in, valid_out, dato_out, palabra_corr, pos_out, estado_err,
               cnt_simple, cnt_doble
    );
endinterface

// File: rtl/modulo_secuenciador.sv
// SECDED Hamming(7,4)+parity decode sequencer; valid_out rises on the third edge counting the accept edge, 1 word / 3 clk.
// Result held in SALIDA until ready_out; ready_in follows ready_out there so a new word can enter back-to-back.
module modulo_03 (
    input  logic       s0,
    input  logic       s1,
    input  logic       s2,
    input  logic       c0,
    input  logic       c1,
    input  logic       c2,
    input  logic       g0,
    input  logic       g1,
    output logic [3:0] pos_error
);
    assign pos_error = {g0 ^ g1, s2 ^ c2, s1 ^ c1, s0 ^ c0};
endmodule

module modulo_secuenciador #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    modulo_secuenciador_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, CORR, SALIDA} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [7:0]       w;
    logic [3:0]       pos_q;
    logic [3:0]       pos_error;
    logic             valid_q;
    logic [3:0]       dato_q;
    logic [6:0]       corr_q;
    logic [2:0]       pos_q_out;
    logic [1:0]       est_q;
    logic [CNT_W-1:0] cnt_s_q;
    logic [CNT_W-1:0] cnt_d_q;

    logic [2:0]       e;
    logic             eg;
    logic [6:0]       corr_n;
    logic [2:0]       pos_n;
    logic [1:0]       est_n;
    logic             inc_simple;
    logic             inc_doble;

    modulo_03 u_cmp (
        .s0        (w[2] ^ w[4] ^ w[6]),
        .s1        (w[2] ^ w[5] ^ w[6]),
        .s2        (w[4] ^ w[5] ^ w[6]),
        .c0        (w[0]),
        .c1        (w[1]),
        .c2        (w[3]),
        .g0        (^w[6:0]),
        .g1        (w[7]),
        .pos_error (pos_error)
    );

    assign e  = pos_q[2:0];
    assign eg = pos_q[3];

    // Only a nonzero syndrome with broken global parity is a correctable single error.
    always_comb begin
        corr_n = w[6:0];
        pos_n  = 3'd0;
        est_n  = 2'b00;
        case ({e != 3'd0, eg})
            2'b01: est_n = 2'b11;
            2'b11: begin
                est_n  = 2'b01;
                pos_n  = e;
                corr_n = w[6:0] ^ (7'd1 << (e - 3'd1));
            end
            2'b10: begin
                est_n = 2'b10;
                pos_n = e;
            end
            default: est_n = 2'b00;
        endcase
    end

    assign inc_simple = (state == CORR) && est_n[0];
    assign inc_doble  = (state == CORR) && (est_n == 2'b10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w         <= 8'd0;
            pos_q     <= 4'd0;
            valid_q   <= 1'b0;
            dato_q    <= 4'd0;
            corr_q    <= 7'd0;
            pos_q_out <= 3'd0;
            est_q     <= 2'b00;
            cnt_s_q   <= '0;
            cnt_d_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        w     <= bus.palabra_in;
                        state <= CALC;
                    end
                end
                CALC: begin
                    pos_q <= pos_error;
                    state <= CORR;
                end
                CORR: begin
                    corr_q    <= corr_n;
                    dato_q    <= {corr_n[6], corr_n[5], corr_n[4], corr_n[2]};
                    pos_q_out <= pos_n;
                    est_q     <= est_n;
                    valid_q   <= 1'b1;
                    state     <= SALIDA;
                end
                SALIDA: begin
                    if (bus.ready_out) begin
                        valid_q <= 1'b0;
                        if (bus.valid_in) begin
                            w     <= bus.palabra_in;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.clr_cnt) begin
                cnt_s_q <= '0;
                cnt_d_q <= '0;
            end else begin
                if (inc_simple && cnt_s_q != CNT_MAX) cnt_s_q <= cnt_s_q + 1'b1;
                if (inc_doble  && cnt_d_q != CNT_MAX) cnt_d_q <= cnt_d_q + 1'b1;
            end
        end
    end

    // Gated by rst so the producer never sees ready while reset is held.
    assign bus.ready_in     = !rst && ((state == IDLE) || ((state == SALIDA) && bus.ready_out));
    assign bus.valid_out    = valid_q;
    assign bus.dato_out     = dato_q;
    assign bus.palabra_corr = corr_q;
    assign bus.pos_out      = pos_q_out;
    assign bus.estado_err   = est_q;
    assign bus.cnt_simple   = cnt_s_q;
    assign bus.cnt_doble    = cnt_d_q;
endmodule
